uart_rx_ctrl: RTL

Controller that sequences the UART receiver core: drives its rx_en/rx_rst, collects completed bytes into an internal RX FIFO, and tracks framing and overrun errors. After a framing error it runs a guard interval before re-arming, so a line break cannot retrigger the receiver. Sits between the receiver and the APB register block, which pops data and reads status.

---
 rtl/uart_rx_ctrl.sv | 239 +++++++++++++++++++++++
 1 files changed

// File: rtl/uart_rx_ctrl.sv
`timescale 1ns/1ps
// Purpose: sequences the UART receiver core, buffers received bytes in an RX FIFO, tracks errors.
// Latency: a pushed byte is visible on rd_data the cycle after rx_done_tick (first-word fall-through).
// Backpressure: none toward the receiver; a byte arriving on a full FIFO with no pop is dropped (overrun).
//
// Ports:
//   clk, PRESETn                 clock, async active-low reset
//   cfg_enable/cfg_flush         receive enable level, flush pulse (FIFO + receiver reset)
//   clr_status                   clears overrun, frame_err, err_cnt, timeout
//   s_tick, rx_*                 receiver interface (16x tick, byte/done/error/busy)
//   rx_en, rx_rst                receiver enable and synchronous reset pulse
//   rd_en, rd_data, empty, full, level   APB-side FIFO pop interface
//   overrun, frame_err, err_cnt, timeout, irq_rx, irq_err   status and interrupts
// Optional: define UART_RX_TIMEOUT_EN to build the RX inactivity timeout.
module uart_rx_ctrl #(
    parameter int DEPTH         = 16,
    parameter int WATERMARK     = 8,
    parameter int GUARD_TICKS   = 32,
    parameter int TIMEOUT_TICKS = 640
) (
    input  logic                     clk,
    input  logic                     PRESETn,
    input  logic                     cfg_enable,
    input  logic                     cfg_flush,
    input  logic                     clr_status,
    input  logic                     s_tick,
    input  logic [7:0]               rx_dout,
    input  logic                     rx_done_tick,
    input  logic                     rx_error_tick,
    input  logic                     rx_busy,
    output logic                     rx_en,
    output logic                     rx_rst,
    input  logic                     rd_en,
    output logic [7:0]               rd_data,
    output logic                     empty,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     overrun,
    output logic                     frame_err,
    output logic [7:0]               err_cnt,
    output logic                     timeout,
    output logic                     irq_rx,
    output logic                     irq_err
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam int GW = $clog2(GUARD_TICKS + 1);

    typedef enum logic [1:0] {
        ST_OFF   = 2'd0,
        ST_RUN   = 2'd1,
        ST_GUARD = 2'd2,
        ST_FLUSH = 2'd3
    } state_t;

    state_t          state_q, state_d;
    logic [GW-1:0]   guard_q, guard_d;
    logic            rx_en_q, rx_rst_q;

    logic [7:0]      mem [DEPTH];
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]   level_q, level_d;

    logic            overrun_q, overrun_d;
    logic            frame_err_q, frame_err_d;
    logic [7:0]      err_cnt_q, err_cnt_d;

    logic            flushing;
    logic            empty_w, full_w;
    logic            push_req, do_push, do_pop, drop;
    logic            err_evt;

    // ---------------- sequencing FSM ----------------
    always_comb begin
        state_d = state_q;
        guard_d = guard_q;
        case (state_q)
            ST_OFF: begin
                if (cfg_flush)       state_d = ST_FLUSH;
                else if (cfg_enable) state_d = ST_RUN;
            end
            ST_RUN: begin
                if (cfg_flush)          state_d = ST_FLUSH;
                else if (!cfg_enable)   state_d = ST_OFF;
                else if (rx_error_tick) begin
                    state_d = ST_GUARD;
                    guard_d = '0;
                end
            end
            ST_GUARD: begin
                if (cfg_flush) begin
                    state_d = ST_FLUSH;
                end else if (s_tick) begin
                    // This tick is the GUARD_TICKS-th one spent disabled.
                    if (guard_q == GW'(GUARD_TICKS - 1))
                        state_d = cfg_enable ? ST_RUN : ST_OFF;
                    else
                        guard_d = guard_q + GW'(1);
                end
            end
            ST_FLUSH: begin
                state_d = cfg_enable ? ST_RUN : ST_OFF;
            end
            default: state_d = ST_OFF;
        endcase
    end

    always_ff @(posedge clk or negedge PRESETn) begin
        if (!PRESETn) begin
            state_q  <= ST_OFF;
            guard_q  <= '0;
            rx_en_q  <= 1'b0;
            rx_rst_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            guard_q  <= guard_d;
            // Registered copies so rx_en/rx_rst track the state being entered.
            rx_en_q  <= (state_d == ST_RUN);
            rx_rst_q <= (state_d == ST_FLUSH) ||
                        ((state_q != ST_GUARD) && (state_d == ST_GUARD));
        end
    end

    // ---------------- RX FIFO ----------------
    assign flushing = (state_q == ST_FLUSH);
    assign empty_w  = (level_q == '0);
    assign full_w   = (level_q == LW'(DEPTH));
    assign push_req = rx_en_q && rx_done_tick;
    assign do_pop   = rd_en && !empty_w && !flushing;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts the byte.
    assign do_push  = push_req && (!full_w || do_pop);
    assign drop     = push_req && full_w && !do_pop;
    assign err_evt  = rx_en_q && rx_error_tick;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (flushing) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            level_d  = '0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
            if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
            case ({do_push, do_pop})
                2'b10:   level_d = level_q + LW'(1);
                2'b01:   level_d = level_q - LW'(1);
                default: level_d = level_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr_q] <= rx_dout;
    end

    // ---------------- sticky status ----------------
    always_comb begin
        overrun_d   = clr_status ? 1'b0 : overrun_q;
        frame_err_d = clr_status ? 1'b0 : frame_err_q;
        err_cnt_d   = clr_status ? 8'h00 : err_cnt_q;
        // New events are applied after the clear so a coincident set wins.
        if (drop)    overrun_d   = 1'b1;
        if (err_evt) frame_err_d = 1'b1;
        if (err_evt && (err_cnt_d != 8'hFF)) err_cnt_d = err_cnt_d + 8'h01;
    end

    always_ff @(posedge clk or negedge PRESETn) begin
        if (!PRESETn) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            level_q     <= '0;
            overrun_q   <= 1'b0;
            frame_err_q <= 1'b0;
            err_cnt_q   <= 8'h00;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            level_q     <= level_d;
            overrun_q   <= overrun_d;
            frame_err_q <= frame_err_d;
            err_cnt_q   <= err_cnt_d;
        end
    end

    // ---------------- optional RX timeout ----------------
`ifdef UART_RX_TIMEOUT_EN
    logic [15:0] to_cnt_q, to_cnt_d;
    logic        timeout_q, timeout_d;

    always_comb begin
        to_cnt_d  = to_cnt_q;
        timeout_d = timeout_q;
        if (flushing || do_push || do_pop || empty_w)
            to_cnt_d = '0;
        else if (s_tick && !rx_busy && (to_cnt_q != 16'(TIMEOUT_TICKS)))
            to_cnt_d = to_cnt_q + 16'd1;   // holds once the limit is reached

        if (clr_status || do_pop || flushing)
            timeout_d = 1'b0;
        if (!flushing && (to_cnt_d == 16'(TIMEOUT_TICKS)))
            timeout_d = 1'b1;
    end

    always_ff @(posedge clk or negedge PRESETn) begin
        if (!PRESETn) begin
            to_cnt_q  <= '0;
            timeout_q <= 1'b0;
        end else begin
            to_cnt_q  <= to_cnt_d;
            timeout_q <= timeout_d;
        end
    end

    assign timeout = timeout_q;
    assign irq_rx  = (level_q >= LW'(WATERMARK)) || timeout_q;
`else
    logic unused_rx_busy;
    assign unused_rx_busy = rx_busy;
    assign timeout        = 1'b0;
    assign irq_rx         = (level_q >= LW'(WATERMARK));
`endif

    // ---------------- outputs ----------------
    assign rx_en     = rx_en_q;
    assign rx_rst    = rx_rst_q;
    assign empty     = empty_w;
    assign full      = full_w;
    assign level     = level_q;
    assign rd_data   = empty_w ? 8'h00 : mem[rd_ptr_q];
    assign overrun   = overrun_q;
    assign frame_err = frame_err_q;
    assign err_cnt   = err_cnt_q;
    assign irq_err   = overrun_q | frame_err_q;

endmodule
